mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes independent load/store requesters (instruction fetch, data access, and later DMA/debug) onto the single external memory handshake (addr, data_in, data_out, omem_re, omem_wr, mem_ready).
- Generalises the fixed two-port memory front end to NPORTS channels, with selectable round-robin or fixed priority, latched request payload, per-channel response pulses and a mem_ready watchdog.

Parameters:
- NPORTS, 2, number of requester channels (>=1)
- DATA_W, 32, data width
- ADDR_W, 32, address width
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- TIMEOUT, 255, max cycles waiting for mem_ready before abort; 0 = watchdog disabled

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NPORTS  channel i requests an access
- req_wr  in  NPORTS  1 = store, 0 = load
- req_addr  in  NPORTS*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NPORTS*DATA_W  packed store data
- req_ready  out  NPORTS  one-cycle accept pulse to the granted channel
- rsp_valid  out  NPORTS  one-cycle completion pulse
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid
- rsp_err  out  1  timeout abort, valid with rsp_valid
- addr  out  ADDR_W  external memory address
- data_in  out  DATA_W  external write data
- data_out  in  DATA_W  external read data
- omem_re  out  1  external read enable
- omem_wr  out  1  external write enable
- mem_ready  in  1  external access complete

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; round-robin pointer=NPORTS-1, so channel 0 is granted first; watchdog=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is set, pick a winner g. RR mode searches from pointer+1 modulo NPORTS. Fixed mode picks the lowest set index.
  - Assert req_ready[g] combinationally in this cycle.
  - Latch addr, wdata, wr and g; go to ISSUE; update pointer to g (RR only).
- Requesters hold payload stable until req_ready; they may drop or change it afterwards, since the payload is latched.
- ISSUE:
  - addr and data_in are driven from the latched values.
  - omem_re = ~wr, omem_wr = wr; held high for the whole state.
  - mem_ready is sampled only in ISSUE. When mem_ready=1, capture data_out (load) or 0 (store) into rsp_rdata, set rsp_err=0, go to RESP.
  - Watchdog increments each ISSUE cycle. When TIMEOUT!=0 and the count reaches TIMEOUT with no mem_ready: rsp_rdata=0, rsp_err=1, go to RESP.
  - Watchdog width is clog2(TIMEOUT+1); it clears on leaving ISSUE.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; omem_re and omem_wr are 0.
  - Next state is IDLE, so back-to-back grants are at least 3 cycles apart.
- Latency: from the req_ready cycle, the external enable rises on the next edge. rsp_valid follows one cycle after the cycle in which mem_ready was sampled.
  - Zero-wait memory gives: accept (cycle 0), issue (cycle 1), rsp (cycle 2).
- Boundary conditions:
  - All channels requesting in RR: grants rotate 0,1,..,NPORTS-1,0.
  - A channel not requesting is skipped with no lost cycle.
  - NPORTS=1: the pointer is degenerate and channel 0 is always granted.
  - mem_ready high outside ISSUE is ignored.
  - req_valid deasserting after acceptance does not cancel the access.
  - A new req_valid during ISSUE/RESP is held off; req_ready stays 0 for all channels.
  - rsp_rdata and rsp_err hold their last values between responses.
  - Reset mid-ISSUE drops the access immediately: no rsp_valid, enables cleared, pointer reset.
  - At most one bit of req_ready and of rsp_valid is ever set.

Test Plan:
- NPORTS=2, RR, mem_ready tied 1; channel 0 loads addr 0x100 with data_out=0xDEADBEEF -> req_ready[0] in cycle 0, omem_re=1 and addr=0x100 in cycle 1, rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF in cycle 2.
- NPORTS=4, RR; all four req_valid held high, zero-wait memory -> grant order 0,1,2,3,0,1; each rsp_valid pulse is 3 cycles apart.
- PRIO_MODE=1, NPORTS=3; channels 1 and 2 requesting continuously -> channel 1 is always granted. Drop channel 1 -> channel 2 is granted at the next IDLE.
- Channel 1 stores 0x12345678 to 0x200, mem_ready delayed 5 cycles -> omem_wr=1 and data_in=0x12345678 for 5 cycles; rsp_valid[1]=1, rsp_err=0, rsp_rdata=0.
- TIMEOUT=8, mem_ready held 0 -> omem_re high for 8 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0; the next request proceeds normally.
- Assert rst=0 in cycle 2 of a stalled ISSUE -> omem_re drops asynchronously; no rsp_valid; after release, channel 0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester channels and the external memory handshake of mem_port_arbiter.
// slave: the arbiter's view; master: the requester/memory environment's view.
// Packed per-channel payloads: channel i sits at [i*W +: W].
interface mem_port_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [NPORTS-1:0]        req_valid;
  logic [NPORTS-1:0]        req_wr;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS*DATA_W-1:0] req_wdata;
  logic [NPORTS-1:0]        req_ready;
  logic [NPORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        data_in;
  logic [DATA_W-1:0]        data_out;
  logic                     omem_re;
  logic                     omem_wr;
  logic                     mem_ready;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, data_out, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_in, omem_re, omem_wr
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, data_out, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_in, omem_re, omem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates NPORTS load/store channels onto one external memory port (RR or fixed priority).
// Latency: accept in cycle 0, enables from cycle 1 until mem_ready/timeout, rsp_valid one cycle later.
// Backpressure: one access in flight; req_ready only pulses in IDLE, other requests wait un-acked.
module mem_port_arbiter #(
  parameter int NPORTS    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [PW-1:0]     cur_idx;
  req_t              cur;
  logic [WW-1:0]     wdog;
  logic              wd_expire;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Winner search: lowest index in fixed mode, first requester after ptr in RR mode.
  // Loops run from lowest to highest preference so the last hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (PRIO_MODE != 0) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end else begin
      for (int k = NPORTS; k >= 1; k--) begin
        idx = PW'((int'(ptr) + k) % NPORTS);
        if (bus.req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  // The count reaches TIMEOUT in this cycle if it already holds TIMEOUT-1.
  assign wd_expire = (TIMEOUT != 0) && ((int'(wdog) + 1) >= TIMEOUT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and the handshake outputs decoded from the current state.
  // req_ready is also gated by rst so no accept is signalled while held in reset.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.omem_re   = 1'b0;
    bus.omem_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && rst) begin
          bus.req_ready[gnt_idx] = 1'b1;
          state_nxt              = ISSUE;
        end
      end
      ISSUE: begin
        bus.omem_re = ~cur.wr;
        bus.omem_wr = cur.wr;
        if (bus.mem_ready || wd_expire) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid[cur_idx] = 1'b1;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, RR pointer, watchdog and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= PW'(NPORTS - 1);
      cur_idx <= '0;
      cur     <= '0;
      wdog    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur.wr    <= bus.req_wr[gnt_idx];
            cur.addr  <= bus.req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
            cur.wdata <= bus.req_wdata[int'(gnt_idx) * DATA_W +: DATA_W];
            cur_idx   <= gnt_idx;
            if (PRIO_MODE == 0) ptr <= gnt_idx;
          end
          wdog <= '0;
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            rdata_q <= cur.wr ? '0 : bus.data_out;
            err_q   <= 1'b0;
            wdog    <= '0;
          end else if (wd_expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            wdog    <= '0;
          end else if (TIMEOUT != 0) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: wdog <= '0;
      endcase
    end
  end

  assign bus.addr      = cur.addr;
  assign bus.data_in   = cur.wdata;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut_a is 4-port round-robin with an 8-cycle watchdog,
// dut_b is 3-port fixed priority with the watchdog disabled. A transaction-level
// model is compared against both every cycle; directed literals pin the model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NPORTS(4), .DATA_W(32), .ADDR_W(32)) ia ();
  mem_port_arbiter_if #(.NPORTS(3), .DATA_W(32), .ADDR_W(32)) ib ();

  mem_port_arbiter #(.NPORTS(4), .DATA_W(32), .ADDR_W(32), .PRIO_MODE(0), .TIMEOUT(8))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  mem_port_arbiter #(.NPORTS(3), .DATA_W(32), .ADDR_W(32), .PRIO_MODE(1), .TIMEOUT(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  // Memory responder: ready once an enable has been high for lat cycles, unless stalled.
  int          lat   = 1;
  bit          stall = 1'b0;
  logic [31:0] dout  = 32'h0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  always @(posedge clk) begin
    cnt_a <= (ia.omem_re || ia.omem_wr) ? cnt_a + 1 : 0;
    cnt_b <= (ib.omem_re || ib.omem_wr) ? cnt_b + 1 : 0;
  end
  assign ia.mem_ready = !stall && (cnt_a >= lat - 1);
  assign ib.mem_ready = !stall && (cnt_b >= lat - 1);
  assign ia.data_out  = dout;
  assign ib.data_out  = dout;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for a request, 1 access outstanding on the memory, 2 reporting completion
  typedef struct {
    int          phase;
    int          g;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          waited;
    int          ptr;
    logic [31:0] rdata;
    bit          err;
  } mdl_t;

  function automatic mdl_t mreset(input int n);
    mdl_t m;
    m.phase = 0; m.g = 0; m.wr = 0; m.a = '0; m.wd = '0;
    m.waited = 0; m.ptr = n - 1; m.rdata = '0; m.err = 0;
    return m;
  endfunction

  function automatic int pick(input mdl_t m, input logic [3:0] v, input int n, input bit prio);
    if (prio) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int j;
        j = (m.ptr + k) % n;
        if (v[j]) return j;
      end
    end
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t m0, input logic [3:0] v, input logic [3:0] wr,
                                input logic [127:0] adrs, input logic [127:0] wds,
                                input bit mrdy, input logic [31:0] dat, input int n,
                                input bit prio, input int tmo);
    mdl_t m;
    int   g;
    m = m0;
    case (m.phase)
      0: begin
        g = pick(m, v, n, prio);
        if (g >= 0) begin
          m.g = g; m.wr = wr[g]; m.a = adrs[g*32 +: 32]; m.wd = wds[g*32 +: 32];
          if (!prio) m.ptr = g;
          m.phase = 1; m.waited = 0;
        end
      end
      1: begin
        m.waited++;
        if (mrdy) begin
          m.rdata = m.wr ? 32'h0 : dat; m.err = 0; m.phase = 2;
        end else if (tmo != 0 && m.waited >= tmo) begin
          m.rdata = 32'h0; m.err = 1; m.phase = 2;
        end
      end
      default: m.phase = 0;
    endcase
    return m;
  endfunction

  task automatic chk_dut(input string nm, input mdl_t m, input bit r, input logic [3:0] v,
                         input int n, input bit prio, input logic [3:0] rdy,
                         input logic [3:0] rv, input logic [31:0] rdata, input logic err,
                         input logic [31:0] adr, input logic [31:0] din,
                         input logic re, input logic we);
    logic [3:0] er;
    logic [3:0] ev;
    int         g;
    er = '0; ev = '0;
    if (r && m.phase == 0) begin
      g = pick(m, v, n, prio);
      if (g >= 0) er[g] = 1'b1;
    end
    if (m.phase == 2) ev[m.g] = 1'b1;
    chk(nm, {21'b0, rdy, rv, rdata, err, adr, din, re, we},
            {21'b0, er, ev, m.rdata, m.err, m.a, m.wd,
             (m.phase == 1 && !m.wr), (m.phase == 1 && m.wr)});
  endtask

  mdl_t ma, mb, ma_n, mb_n;

  // Compare both DUTs against the model mid-cycle, then precompute the next model state.
  always @(negedge clk) begin
    if (!rst) begin
      ma = mreset(4);
      mb = mreset(3);
    end
    chk_dut("cycle_a", ma, rst, ia.req_valid, 4, 1'b0, ia.req_ready, ia.rsp_valid,
            ia.rsp_rdata, ia.rsp_err, ia.addr, ia.data_in, ia.omem_re, ia.omem_wr);
    chk_dut("cycle_b", mb, rst, {1'b0, ib.req_valid}, 3, 1'b1, {1'b0, ib.req_ready},
            {1'b0, ib.rsp_valid}, ib.rsp_rdata, ib.rsp_err, ib.addr, ib.data_in,
            ib.omem_re, ib.omem_wr);
    if (rst) begin
      ma_n = step(ma, ia.req_valid, ia.req_wr, ia.req_addr, ia.req_wdata, ia.mem_ready,
                  ia.data_out, 4, 1'b0, 8);
      mb_n = step(mb, {1'b0, ib.req_valid}, {1'b0, ib.req_wr}, {32'h0, ib.req_addr},
                  {32'h0, ib.req_wdata}, ib.mem_ready, ib.data_out, 3, 1'b1, 0);
    end else begin
      ma_n = ma;
      mb_n = mb;
    end
  end

  // Advance the model on the clock edge while out of reset.
  always @(posedge clk) begin
    if (rst) begin
      ma = ma_n;
      mb = mb_n;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  initial begin
    logic [23:0]  seq;
    logic [3:0]   gsel;
    logic [36:0]  cap;
    int ng, nr, first_r, last_r, nwr, nre, rsp_c, g2, n1, n2;

    rst = 1'b0;
    ia.req_valid = 4'hF; ia.req_wr = '0; ia.req_addr = '0; ia.req_wdata = '0;
    ib.req_valid = '0;   ib.req_wr = '0; ib.req_addr = '0; ib.req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      ia.req_addr[i*32 +: 32]  = 32'h1000 + 32'(i * 16);
      ia.req_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    for (int i = 0; i < 3; i++) ib.req_addr[i*32 +: 32] = 32'h2000 + 32'(i * 4);
    dout = 32'h5A5A_0001;
    repeat (3) cyc();
    #1;
    chk("reset_state", {ia.req_ready, ia.rsp_valid, ia.omem_re, ia.omem_wr, ia.addr,
                        ia.data_in, ia.rsp_rdata, ia.rsp_err}, 128'h0);
    ia.req_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();

    // Round-robin rotation with all four channels requesting, zero-wait memory.
    ia.req_valid = 4'hF;
    seq = '0; ng = 0; nr = 0; first_r = -1; last_r = -1;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (ia.req_ready != 4'h0) begin seq = {seq[19:0], oh_idx(ia.req_ready)}; ng++; end
      if (ia.rsp_valid != 4'h0) begin nr++; if (first_r < 0) first_r = c; last_r = c; end
      cyc();
    end
    ia.req_valid = '0;
    chk("rr_order", seq, 24'h012301);
    chk("rr_counts", {ng, nr}, {32'd6, 32'd6});
    chk("rr_rsp_spacing", {first_r, last_r}, {32'd2, 32'd17});
    cyc();

    // Skip idle channels: pointer at 1, channels 3 and 0 requesting.
    ia.req_valid = 4'b1001;
    #1 chk("skip_ch3", ia.req_ready, 4'b1000);
    repeat (3) cyc();
    #1 chk("skip_then_ch0", ia.req_ready, 4'b0001);
    cyc();
    ia.req_valid = '0;
    repeat (3) cyc();

    // Load from channel 0; payload changed after accept must not leak through.
    ia.req_addr[0 +: 32] = 32'h100; ia.req_wr = '0; dout = 32'hDEADBEEF;
    ia.req_valid = 4'b0001;
    #1 chk("ld_accept", ia.req_ready, 4'b0001);
    cyc();
    ia.req_valid = '0; ia.req_addr[0 +: 32] = 32'hFFFF_0000;
    #1 chk("ld_issue", {ia.omem_re, ia.omem_wr, ia.addr}, {1'b1, 1'b0, 32'h100});
    cyc();
    #1 chk("ld_rsp", {ia.rsp_valid, ia.rsp_rdata, ia.rsp_err}, {4'b0001, 32'hDEADBEEF, 1'b0});
    cyc();

    // Store from channel 1 with 5-cycle memory; channel 2 requests while it is busy.
    lat = 5;
    ia.req_wr = 4'b0010; ia.req_addr[32 +: 32] = 32'h200; ia.req_wdata[32 +: 32] = 32'h12345678;
    ia.req_valid = 4'b0010;
    #1 chk("st_accept", ia.req_ready, 4'b0010);
    cyc();
    ia.req_valid = 4'b0100; ia.req_wr = '0; ia.req_addr[64 +: 32] = 32'h300;
    nwr = 0; rsp_c = -1; g2 = -1; gsel = '0; cap = '0;
    for (int c = 1; c < 10; c++) begin
      #1;
      if (ia.omem_wr && ia.data_in == 32'h12345678 && ia.addr == 32'h200) nwr++;
      if (ia.rsp_valid != 4'h0 && rsp_c < 0) begin
        rsp_c = c; cap = {ia.rsp_valid, ia.rsp_rdata, ia.rsp_err};
      end
      if (ia.req_ready != 4'h0 && g2 < 0) begin g2 = c; gsel = ia.req_ready; end
      cyc();
    end
    ia.req_valid = '0;
    chk("st_wr_cycles", nwr, 5);
    chk("st_rsp", {rsp_c, cap}, {32'd6, 4'b0010, 32'h0, 1'b0});
    chk("holdoff_grant", {g2, gsel}, {32'd7, 4'b0100});
    repeat (5) cyc();
    lat = 1;

    // Watchdog abort on channel 0, then a normal load on channel 1.
    stall = 1'b1;
    ia.req_addr[0 +: 32] = 32'h400; ia.req_valid = 4'b0001;
    cyc();
    ia.req_valid = '0;
    nre = 0; rsp_c = -1; cap = '0;
    for (int c = 1; c < 11; c++) begin
      #1;
      if (ia.omem_re) nre++;
      if (ia.rsp_valid != 4'h0 && rsp_c < 0) begin
        rsp_c = c; cap = {ia.rsp_valid, ia.rsp_rdata, ia.rsp_err};
      end
      cyc();
    end
    chk("to_re_cycles", nre, 8);
    chk("to_rsp", {rsp_c, cap}, {32'd9, 4'b0001, 32'h0, 1'b1});
    stall = 1'b0; dout = 32'hCAFEF00D;
    ia.req_addr[32 +: 32] = 32'h500; ia.req_valid = 4'b0010;
    #1 chk("after_to_accept", ia.req_ready, 4'b0010);
    cyc();
    ia.req_valid = '0;
    cyc();
    #1 chk("after_to_rsp", {ia.rsp_valid, ia.rsp_rdata, ia.rsp_err}, {4'b0010, 32'hCAFEF00D, 1'b0});
    cyc();

    // Reset during a stalled access on channel 2.
    stall = 1'b1;
    ia.req_addr[64 +: 32] = 32'h600; ia.req_valid = 4'b0100;
    cyc();
    ia.req_valid = '0;
    cyc();
    #1 chk("rst_pre_issue", ia.omem_re, 1'b1);
    rst = 1'b0;
    #1 chk("rst_async_drop", {ia.omem_re, ia.omem_wr, ia.rsp_valid}, 6'b0);
    repeat (2) cyc();
    ia.req_valid = 4'b0101; stall = 1'b0;
    rst = 1'b1;
    #1 chk("rst_first_grant", ia.req_ready, 4'b0001);
    cyc();
    ia.req_valid = '0;
    repeat (4) cyc();

    // Fixed priority on dut_b: channel 1 beats channel 2 until it drops.
    ib.req_valid = 3'b110;
    n1 = 0; n2 = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (ib.req_ready == 3'b010) n1++;
      if (ib.req_ready == 3'b100) n2++;
      cyc();
    end
    chk("prio_ch1_only", {n1, n2}, {32'd3, 32'd0});
    ib.req_valid = 3'b100;
    #1 chk("prio_drop_ch2", ib.req_ready, 3'b100);
    cyc();
    ib.req_valid = '0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
